core_ctx_sequencer: RTL

Parametrised context sequencer for the multi-cycle reference CPU. It holds the architectural context register and selects the per-state next context and bus requests by current state. It keeps a ring of committed-context checkpoints that the debug/interrupt logic can roll back to. It sits between the per-state datapath stages and the instruction/data bus interfaces.

---
 rtl/core_ctx_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/core_ctx_sequencer.sv
// Context sequencer for the multi-cycle reference CPU.
// Holds the architectural context, selects the next context and the bus
// requests by the current state, and keeps a ring of committed-context
// checkpoints that can be rolled back to.
// Handshake: no valid/ready pair. The ctx update happens on every clk edge
// unless stall is high. rb_valid is a single-cycle request that is taken
// on the same edge when a checkpoint exists, and rejected (rb_err) when
// none does.
module core_ctx_sequencer #(
    parameter int                 NUM_STATES    = 16,
    parameter int                 STATE_W       = 4,
    parameter int                 CTX_W         = 1024,
    parameter int                 ZERO_LSB      = 0,
    parameter int                 ZERO_W        = 0,
    parameter int                 HARDWIRE_NPC  = 1,
    parameter int                 IREQ_W        = 64,
    parameter int                 DREQ_W        = 128,
    parameter int                 CKPT_DEPTH    = 4,
    parameter int                 COMMIT_STATE  = 1,
    parameter int                 UNKNOWN_STATE = NUM_STATES,
    parameter logic [CTX_W-1:0]   RESET_CTX     = '0,
    localparam int                IDX_W         = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1,
    localparam int                CNT_W         = $clog2(CKPT_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_STATES*CTX_W-1:0]  out_ctx,
    input  logic [NUM_STATES*IREQ_W-1:0] out_ireq,
    input  logic [NUM_STATES*DREQ_W-1:0] out_dreq,
    input  logic                         stall,
    input  logic                         rb_valid,
    input  logic [IDX_W-1:0]             rb_idx,
    output logic [CTX_W-1:0]             ctx,
    output logic [IREQ_W-1:0]            ireq,
    output logic [DREQ_W-1:0]            dreq,
    output logic [CTX_W-1:0]             ckpt_newest,
    output logic [CNT_W-1:0]             ckpt_count,
    output logic [63:0]                  commit_cnt,
    output logic                         bad_state,
    output logic                         rb_err
);

    // Bits of the context that are hardwired to zero in every accepted context.
    function automatic logic [CTX_W-1:0] zero_mask_f();
        logic [CTX_W-1:0] m;
        for (int i = 0; i < CTX_W; i++) begin
            m[i] = (i >= ZERO_LSB) && (i < ZERO_LSB + ZERO_W);
        end
        return m;
    endfunction

    localparam logic [CTX_W-1:0]   ZERO_MASK = zero_mask_f();
    localparam logic [STATE_W:0]   NS_L      = NUM_STATES[STATE_W:0];
    localparam logic [STATE_W-1:0] UNK_L     = UNKNOWN_STATE[STATE_W-1:0];
    localparam logic [STATE_W-1:0] COMMIT_L  = COMMIT_STATE[STATE_W-1:0];
    localparam logic [IDX_W-1:0]   IDX_MASK  = IDX_W'(CKPT_DEPTH - 1);
    localparam logic [IDX_W-1:0]   ONE_I     = IDX_W'(1);
    localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   FULL_C    = CNT_W'(CKPT_DEPTH);

    logic [CTX_W-1:0]   ring [CKPT_DEPTH];
    logic [IDX_W-1:0]   wp;
    logic [STATE_W-1:0] cur_state;
    logic [CTX_W-1:0]   raw_ctx;
    logic [CTX_W-1:0]   new_ctx;
    logic               has_ckpt;
    logic               rb_take;
    logic               commit;
    logic [CNT_W-1:0]   rb_ext;
    logic [CNT_W-1:0]   cnt_m1;
    logic [CNT_W-1:0]   rb_k;
    logic [IDX_W-1:0]   rb_k_i;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   newest_idx;

    assign cur_state = ctx[STATE_W-1:0];

    // Next-context selection: pick the candidate for the current state, then
    // apply the zero field, hardwired next_pc and out-of-range state clamp.
    always_comb begin
        raw_ctx = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (cur_state == STATE_W'(i)) begin
                raw_ctx = out_ctx[i*CTX_W +: CTX_W];
            end
        end
        new_ctx = raw_ctx & ~ZERO_MASK;
        if (HARDWIRE_NPC != 0) begin
            new_ctx[STATE_W+32 +: 32] = new_ctx[STATE_W +: 32] + 32'd4;
        end
        bad_state = {1'b0, new_ctx[STATE_W-1:0]} >= NS_L;
        if (bad_state) begin
            new_ctx[STATE_W-1:0] = UNK_L;
        end
    end

    // Bus requests of the current state; an unknown state requests nothing.
    always_comb begin
        ireq = '0;
        dreq = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (cur_state == STATE_W'(i)) begin
                ireq = out_ireq[i*IREQ_W +: IREQ_W];
                dreq = out_dreq[i*DREQ_W +: DREQ_W];
            end
        end
    end

    // Rollback target, newest-checkpoint view and commit decision.
    always_comb begin
        has_ckpt    = ckpt_count != '0;
        rb_take     = rb_valid && has_ckpt;
        rb_err      = rb_valid && !has_ckpt;
        rb_ext      = CNT_W'(rb_idx);
        cnt_m1      = ckpt_count - ONE_C;
        rb_k        = (rb_ext < cnt_m1) ? rb_ext : cnt_m1;
        rb_k_i      = IDX_W'(rb_k);
        rd_idx      = (wp - ONE_I - rb_k_i) & IDX_MASK;
        newest_idx  = (wp - ONE_I) & IDX_MASK;
        ckpt_newest = has_ckpt ? ring[newest_idx] : RESET_CTX;
        commit      = !rb_take && !stall && (cur_state == COMMIT_L);
    end

    // Context, checkpoint ring and counters: reset > rollback > stall > advance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctx        <= RESET_CTX;
            wp         <= '0;
            ckpt_count <= '0;
            commit_cnt <= '0;
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                ring[i] <= RESET_CTX;
            end
        end else if (rb_take) begin
            // The restored entry stays newest; everything newer is discarded.
            ctx        <= ring[rd_idx];
            wp         <= (wp - rb_k_i) & IDX_MASK;
            ckpt_count <= ckpt_count - rb_k;
        end else if (!stall) begin
            ctx <= new_ctx;
            if (commit) begin
                ring[wp]   <= new_ctx;
                wp         <= (wp + ONE_I) & IDX_MASK;
                ckpt_count <= (ckpt_count == FULL_C) ? ckpt_count : ckpt_count + ONE_C;
                commit_cnt <= commit_cnt + 64'd1;
            end
        end
    end

endmodule
